// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//
// Purpose: bundles the pipeline-side hazard inputs and the stall/flush/mul-div
// status outputs of pipeline_hazard_ctrl into one interface.
//
// Modports:
//   master : pipeline side. Drives the ID/EX/MEM stage information and receives
//            the stall, flush and mul/div status.
//   slave  : the hazard controller. Consumes the stage information and drives
//            the stall, flush and mul/div status.
//
// Signals (stage suffix _D = ID, _E = EX, _M = MEM):
//   RsAddr_D, RtAddr_D   [4:0]  source registers of the ID-stage instruction
//   UsesRt_D                    ID-stage instruction reads rt
//   Branch_D, BranchTaken_D     conditional branch in ID and its compare result
//   Jump_D                      j/jal/jr in ID
//   MulDivOp_D                  HI/LO instruction in ID
//   RegDstAddr_E [4:0], RegWriteEN_E, MemRead_E, MulDivStart_E   EX-stage info
//   RegDstAddr_M [4:0], MemRead_M                                 MEM-stage info
//   StallF, StallD, FlushD, FlushE                                pipeline control
//   MulDivBusy, MulDivDone                                        mul/div status
//   StallCycles, FlushCount [31:0]   only with HAZARD_PERF_CNT_EN defined
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
  logic [4:0]  RsAddr_D;
  logic [4:0]  RtAddr_D;
  logic        UsesRt_D;
  logic        Branch_D;
  logic        BranchTaken_D;
  logic        Jump_D;
  logic        MulDivOp_D;
  logic [4:0]  RegDstAddr_E;
  logic        RegWriteEN_E;
  logic        MemRead_E;
  logic        MulDivStart_E;
  logic [4:0]  RegDstAddr_M;
  logic        MemRead_M;

  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic        MulDivBusy;
  logic        MulDivDone;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles;
  logic [31:0] FlushCount;
`endif

  modport master (
    output RsAddr_D, RtAddr_D, UsesRt_D, Branch_D, BranchTaken_D, Jump_D,
           MulDivOp_D, RegDstAddr_E, RegWriteEN_E, MemRead_E, MulDivStart_E,
           RegDstAddr_M, MemRead_M,
`ifdef HAZARD_PERF_CNT_EN
    input  StallCycles, FlushCount,
`endif
    input  StallF, StallD, FlushD, FlushE, MulDivBusy, MulDivDone
  );

  modport slave (
    input  RsAddr_D, RtAddr_D, UsesRt_D, Branch_D, BranchTaken_D, Jump_D,
           MulDivOp_D, RegDstAddr_E, RegWriteEN_E, MemRead_E, MulDivStart_E,
           RegDstAddr_M, MemRead_M,
`ifdef HAZARD_PERF_CNT_EN
    output StallCycles, FlushCount,
`endif
    output StallF, StallD, FlushD, FlushE, MulDivBusy, MulDivDone
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose: central stall/flush controller for the 5-stage pipeline. Covers the
// hazards forwarding cannot resolve: load-use, branch/jump operands not yet
// available in ID, control flushes for taken branches and jumps, and occupancy
// of the multi-cycle HI/LO multiply/divide unit (tracked by a busy FSM).
//
// Ports:
//   clk    in   pipeline clock, rising edge
//   reset  in   synchronous, active-high reset
//   hz     slave modport of pipeline_hazard_ctrl_if (see that file)
//
// Parameters:
//   MD_LATENCY  cycles the mul/div unit is busy after a start (2..63)
//   CNT_W       busy counter width, 2**CNT_W must exceed MD_LATENCY
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   Adds saturating StallCycles / FlushCount counters on the interface.
//
// Stall and flush outputs are combinational; MulDivBusy/MulDivDone are
// registered FSM outputs.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(MD_LATENCY - 1);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_done;

  logic w_ld_use;
  logic w_br_haz;
  logic w_md_haz;
  logic w_stall;
  logic w_flush_d;

  // r0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign w_ld_use = hz.MemRead_E &&
                    (reg_match(hz.RsAddr_D, hz.RegDstAddr_E) ||
                     (hz.UsesRt_D && reg_match(hz.RtAddr_D, hz.RegDstAddr_E)));

  // Branches compare in ID, so any producer still in EX, or a load still in
  // MEM, cannot be forwarded in time. The rt check is unconditional here since
  // branch/jr operand usage is not qualified by UsesRt_D.
  assign w_br_haz = (hz.Branch_D || hz.Jump_D) &&
                    ((hz.RegWriteEN_E &&
                      (reg_match(hz.RsAddr_D, hz.RegDstAddr_E) ||
                       reg_match(hz.RtAddr_D, hz.RegDstAddr_E))) ||
                     (hz.MemRead_M &&
                      (reg_match(hz.RsAddr_D, hz.RegDstAddr_M) ||
                       reg_match(hz.RtAddr_D, hz.RegDstAddr_M))));

  // The done cycle releases the stall early to line up with the unit's
  // write-back timing.
  assign w_md_haz = hz.MulDivOp_D && (r_state == MD_BUSY) && !r_done;

  assign w_stall   = w_ld_use || w_br_haz || w_md_haz;
  // An operand stall means the branch outcome is not trustworthy yet.
  assign w_flush_d = (hz.Jump_D || (hz.Branch_D && hz.BranchTaken_D)) && !w_stall;

  assign hz.StallF     = w_stall;
  assign hz.StallD     = w_stall;
  assign hz.FlushE     = w_stall;
  assign hz.FlushD     = w_flush_d;
  assign hz.MulDivBusy = (r_state == MD_BUSY);
  assign hz.MulDivDone = r_done;

  // ---------------------------------------------------------------------------
  // Mul/div busy FSM. r_done is precomputed one cycle ahead so it is high
  // exactly while r_count == 1 in MD_BUSY. A start seen while busy is ignored.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (hz.MulDivStart_E) begin
            r_state <= MD_BUSY;
            r_count <= LP_LOAD;
            r_done  <= (LP_LOAD == CNT_W'(1));
          end
        end
        MD_BUSY: begin
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end else begin
            r_done  <= (r_count == CNT_W'(2));
          end
        end
        default: begin
          r_state <= IDLE;
          r_count <= '0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush_d && (r_flush_count != 32'hFFFF_FFFF))
        r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign hz.StallCycles = r_stall_cycles;
  assign hz.FlushCount  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Two controller instances (MD_LATENCY 4 and 32) share identical stimulus.
// Each cycle the driver computes the expected response from a cycle-indexed
// model (the mul/div unit is described as an interval of busy cycles) and
// pushes it to a queue; the monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if if4 ();
  pipeline_hazard_ctrl_if if32 ();

  pipeline_hazard_ctrl #(.MD_LATENCY(4),  .CNT_W(3)) dut4  (.clk(clk), .reset(reset), .hz(if4));
  pipeline_hazard_ctrl #(.MD_LATENCY(32), .CNT_W(6)) dut32 (.clk(clk), .reset(reset), .hz(if32));

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       uses_rt, branch, taken, jump, mdop;
    logic [4:0] dst_e;
    logic       rw_e, mr_e, mds_e;
    logic [4:0] dst_m;
    logic       mr_m;
  } stim_t;

  typedef struct {
    int          cyc;
    logic        stall [2];
    logic        flushd[2];
    logic        busy  [2];
    logic        done  [2];
    logic [31:0] sc    [2];
    logic [31:0] fc    [2];
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state: the mul/div unit of instance k is busy during
  // cycles md_start[k]+1 .. md_end[k].
  int          lat[2]      = '{4, 32};
  int          md_start[2] = '{-10, -10};
  int          md_end[2]   = '{-10, -10};
  logic [31:0] m_sc[2]     = '{32'd0, 32'd0};
  logic [31:0] m_fc[2]     = '{32'd0, 32'd0};
  int          cyc_n       = 0;

  task automatic check(input string name, input int k, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cycle=%0d actual=%0h expected=%0h",
               name, (k == 0) ? 4 : 32, cyc, act, exp);
    end
  endtask

  function automatic bit dep(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    reset = s.rst;
    if4.RsAddr_D = s.rs;        if32.RsAddr_D = s.rs;
    if4.RtAddr_D = s.rt;        if32.RtAddr_D = s.rt;
    if4.UsesRt_D = s.uses_rt;   if32.UsesRt_D = s.uses_rt;
    if4.Branch_D = s.branch;    if32.Branch_D = s.branch;
    if4.BranchTaken_D = s.taken; if32.BranchTaken_D = s.taken;
    if4.Jump_D = s.jump;        if32.Jump_D = s.jump;
    if4.MulDivOp_D = s.mdop;    if32.MulDivOp_D = s.mdop;
    if4.RegDstAddr_E = s.dst_e; if32.RegDstAddr_E = s.dst_e;
    if4.RegWriteEN_E = s.rw_e;  if32.RegWriteEN_E = s.rw_e;
    if4.MemRead_E = s.mr_e;     if32.MemRead_E = s.mr_e;
    if4.MulDivStart_E = s.mds_e; if32.MulDivStart_E = s.mds_e;
    if4.RegDstAddr_M = s.dst_m; if32.RegDstAddr_M = s.dst_m;
    if4.MemRead_M = s.mr_m;     if32.MemRead_M = s.mr_m;
  endtask

  // One pipeline cycle: drive, predict, push, then advance the model past the
  // upcoming clock edge.
  task automatic cyc(input stim_t s);
    exp_t e;
    bit   busy, done, ld, br, md, st, fl;
    @(posedge clk);
    #1;
    apply(s);
    e.cyc = cyc_n;
    ld = s.mr_e && (dep(s.rs, s.dst_e) || (s.uses_rt && dep(s.rt, s.dst_e)));
    br = (s.branch || s.jump) &&
         ((s.rw_e && (dep(s.rs, s.dst_e) || dep(s.rt, s.dst_e))) ||
          (s.mr_m && (dep(s.rs, s.dst_m) || dep(s.rt, s.dst_m))));
    for (int k = 0; k < 2; k++) begin
      busy = (cyc_n > md_start[k]) && (cyc_n <= md_end[k]);
      done = busy && (cyc_n == md_end[k]);
      md   = s.mdop && busy && !done;
      st   = ld || br || md;
      fl   = (s.jump || (s.branch && s.taken)) && !st;
      e.stall[k]  = st;
      e.flushd[k] = fl;
      e.busy[k]   = busy;
      e.done[k]   = done;
      e.sc[k]     = m_sc[k];
      e.fc[k]     = m_fc[k];
      if (s.rst) begin
        md_start[k] = -10;
        md_end[k]   = -10;
        m_sc[k]     = 32'd0;
        m_fc[k]     = 32'd0;
      end else begin
        if (!busy && s.mds_e) begin
          md_start[k] = cyc_n;
          md_end[k]   = cyc_n + lat[k] - 1;
        end
        if (st && m_sc[k] != 32'hFFFF_FFFF) m_sc[k] = m_sc[k] + 32'd1;
        if (fl && m_fc[k] != 32'hFFFF_FFFF) m_fc[k] = m_fc[k] + 32'd1;
      end
    end
    exp_q.push_back(e);
    cyc_n++;
  endtask

  // Monitor: compare every predicted cycle against both instances.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("StallF",     0, e.cyc, 32'(if4.StallF),      32'(e.stall[0]));
      check("StallD",     0, e.cyc, 32'(if4.StallD),      32'(e.stall[0]));
      check("FlushE",     0, e.cyc, 32'(if4.FlushE),      32'(e.stall[0]));
      check("FlushD",     0, e.cyc, 32'(if4.FlushD),      32'(e.flushd[0]));
      check("MulDivBusy", 0, e.cyc, 32'(if4.MulDivBusy),  32'(e.busy[0]));
      check("MulDivDone", 0, e.cyc, 32'(if4.MulDivDone),  32'(e.done[0]));
      check("StallF",     1, e.cyc, 32'(if32.StallF),     32'(e.stall[1]));
      check("StallD",     1, e.cyc, 32'(if32.StallD),     32'(e.stall[1]));
      check("FlushE",     1, e.cyc, 32'(if32.FlushE),     32'(e.stall[1]));
      check("FlushD",     1, e.cyc, 32'(if32.FlushD),     32'(e.flushd[1]));
      check("MulDivBusy", 1, e.cyc, 32'(if32.MulDivBusy), 32'(e.busy[1]));
      check("MulDivDone", 1, e.cyc, 32'(if32.MulDivDone), 32'(e.done[1]));
`ifdef HAZARD_PERF_CNT_EN
      check("StallCycles", 0, e.cyc, if4.StallCycles,  e.sc[0]);
      check("FlushCount",  0, e.cyc, if4.FlushCount,   e.fc[0]);
      check("StallCycles", 1, e.cyc, if32.StallCycles, e.sc[1]);
      check("FlushCount",  1, e.cyc, if32.FlushCount,  e.fc[1]);
`endif
    end
  end

  initial begin
    stim_t s;
    s = idle_s();
    s.rst = 1'b1;
    apply(s);

    // Reset state.
    cyc(s); cyc(s);

    // Load-use, then the load moves to MEM with no branch in ID.
    s = idle_s(); s.mr_e = 1; s.dst_e = 5'd8; s.rs = 5'd8; cyc(s);
    s = idle_s(); s.mr_m = 1; s.dst_m = 5'd8; s.rs = 5'd8; cyc(s);
    // Load-use through rt, with and without UsesRt_D.
    s = idle_s(); s.mr_e = 1; s.dst_e = 5'd5; s.rt = 5'd5; s.uses_rt = 1; cyc(s);
    s.uses_rt = 0; cyc(s);

    // r0 immunity.
    s = idle_s(); s.mr_e = 1; s.dst_e = 5'd0; s.rs = 5'd0; cyc(s);
    s = idle_s(); s.branch = 1; s.rw_e = 1; s.dst_e = 5'd0; cyc(s);

    // Branch after load, taken throughout.
    s = idle_s(); s.branch = 1; s.taken = 1; s.rs = 5'd9;
    s.mr_e = 1; s.rw_e = 1; s.dst_e = 5'd9; cyc(s);
    s.mr_e = 0; s.rw_e = 0; s.dst_e = 5'd0; s.mr_m = 1; s.dst_m = 5'd9; cyc(s);
    s.mr_m = 0; s.dst_m = 5'd0; cyc(s);

    // Mul/div: start pulse, then a HI/LO instruction held in ID.
    s = idle_s(); s.rst = 1; cyc(s);
    s = idle_s(); s.mds_e = 1; cyc(s);
    s = idle_s(); s.mdop = 1;
    for (int i = 0; i < 5; i++) cyc(s);
    // Start while busy (instance 32) must not reload the count.
    s = idle_s(); s.mds_e = 1; cyc(s);
    s = idle_s();
    for (int i = 0; i < 30; i++) cyc(s);

    // Reset at busy cycle 10, then a full interval from a fresh start.
    s = idle_s(); s.rst = 1; cyc(s);
    s = idle_s(); s.mds_e = 1; cyc(s);
    s = idle_s();
    for (int i = 0; i < 9; i++) cyc(s);
    s.rst = 1; cyc(s);
    s = idle_s(); cyc(s);
    s.mds_e = 1; cyc(s);
    s = idle_s();
    for (int i = 0; i < 34; i++) cyc(s);

    // Three load-use stalls and two jumps, then reset clears the counters.
    s = idle_s(); s.rst = 1; cyc(s);
    for (int i = 0; i < 3; i++) begin
      s = idle_s(); s.mr_e = 1; s.dst_e = 5'd3; s.rs = 5'd3; cyc(s);
    end
    for (int i = 0; i < 2; i++) begin
      s = idle_s(); s.jump = 1; s.rs = 5'd31; cyc(s);
    end
    s = idle_s(); cyc(s);
    s.rst = 1; cyc(s);
    s = idle_s(); cyc(s);

    // Randomized traffic over a small register set so matches are frequent.
    for (int i = 0; i < 2500; i++) begin
      s.rst     = ($urandom_range(0, 149) == 0);
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.uses_rt = 1'($urandom);
      s.branch  = ($urandom_range(0, 3) == 0);
      s.taken   = 1'($urandom);
      s.jump    = ($urandom_range(0, 5) == 0);
      s.mdop    = 1'($urandom);
      s.dst_e   = 5'($urandom_range(0, 3));
      s.rw_e    = 1'($urandom);
      s.mr_e    = ($urandom_range(0, 2) == 0);
      s.mds_e   = ($urandom_range(0, 7) == 0);
      s.dst_m   = 5'($urandom_range(0, 3));
      s.mr_m    = ($urandom_range(0, 2) == 0);
      cyc(s);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
